// File: rtl/calc_pkg.sv
// Shared calculator definitions: entry FSM states, operand reset defaults and ALU op codes.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } entry_state_t;

    localparam logic [3:0] DEF_OPERAND = 4'b1111;
    localparam logic [1:0] DEF_CTRL    = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/calc_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, level debounce, and one-cycle rising-edge press pulse.
module calc_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_stable_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any return to the accepted level restarts the hold count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign press  = r_stable & ~r_stable_d;

endmodule

// File: rtl/calc_operand_entry.sv
// Calculator entry stage: collects operand A, operand B and op code one ENTER press at a time.
module calc_operand_entry
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_data,
    input  logic       key_enter,
    input  logic       key_clear,
    output logic [3:0] i1,
    output logic [3:0] i2,
    output logic [1:0] ctrl,
    output logic       operands_valid,
    output logic [1:0] entry_state
);

    logic w_enter_stable;
    logic w_enter_press;
    logic w_clear_stable;
    logic w_clear_press;
    logic w_unused_stable;

    calc_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_enter),
        .stable(w_enter_stable),
        .press (w_enter_press)
    );

    calc_btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_clear_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (key_clear),
        .stable(w_clear_stable),
        .press (w_clear_press)
    );

    assign w_unused_stable = w_enter_stable ^ w_clear_stable;

    entry_state_t r_state;
    logic [3:0]   r_i1;
    logic [3:0]   r_i2;
    logic [1:0]   r_ctrl;
    logic         r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
            r_i1    <= DEF_OPERAND;
            r_i2    <= DEF_OPERAND;
            r_ctrl  <= DEF_CTRL;
            r_valid <= 1'b0;
        end else if (w_clear_press) begin
            // Clear wins over a simultaneous enter; that enter is dropped.
            r_state <= S_A;
            r_i1    <= DEF_OPERAND;
            r_i2    <= DEF_OPERAND;
            r_ctrl  <= DEF_CTRL;
            r_valid <= 1'b0;
        end else if (w_enter_press) begin
            unique case (r_state)
                S_A: begin
                    r_i1    <= key_data;
                    r_valid <= 1'b0;
                    r_state <= S_B;
                end
                S_B: begin
                    r_i2    <= key_data;
                    r_state <= S_OP;
                end
                S_OP: begin
                    r_ctrl  <= key_data[1:0];
                    r_valid <= 1'b1;
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    r_valid <= 1'b0;
                    r_state <= S_A;
                end
            endcase
        end
    end

    assign i1             = r_i1;
    assign i2             = r_i2;
    assign ctrl           = r_ctrl;
    assign operands_valid = r_valid;
    assign entry_state    = r_state;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Self-checking bench for calc_operand_entry: directed scenarios plus random presses vs a model.
module tb_calc_operand_entry;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_data = 4'd0;
    logic       key_enter = 1'b0;
    logic       key_clear = 1'b0;
    logic [3:0] i1;
    logic [3:0] i2;
    logic [1:0] ctrl;
    logic       operands_valid;
    logic [1:0] entry_state;

    always #5 clk = ~clk;

    calc_operand_entry #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_data      (key_data),
        .key_enter     (key_enter),
        .key_clear     (key_clear),
        .i1            (i1),
        .i2            (i2),
        .ctrl          (ctrl),
        .operands_valid(operands_valid),
        .entry_state   (entry_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once D consecutive raw samples, seen through the
    // two-sample synchroniser delay, all differ from the accepted level.
    bit [3:0] m_i1;
    bit [3:0] m_i2;
    bit [1:0] m_ctrl;
    bit       m_valid;
    int       m_step;
    bit       m_st_e;
    bit       m_st_c;
    bit       m_pe;
    bit       m_pc;
    bit       qe[$];
    bit       qc[$];

    function automatic bit window_differs(input bit q[$], input bit st);
        for (int i = 0; i < int'(D); i++) begin
            if (q[i] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_defaults();
        m_i1    = 4'hF;
        m_i2    = 4'hF;
        m_ctrl  = 2'h3;
        m_valid = 1'b0;
        m_step  = 0;
    endtask

    task automatic model_reset();
        model_defaults();
        m_st_e = 1'b0;
        m_st_c = 1'b0;
        m_pe   = 1'b0;
        m_pc   = 1'b0;
        qe.delete();
        qc.delete();
        for (int i = 0; i < int'(D) + 2; i++) begin
            qe.push_back(1'b0);
            qc.push_back(1'b0);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (m_pc) begin
                    model_defaults();
                end else if (m_pe) begin
                    case (m_step)
                        0: begin m_i1 = key_data; m_valid = 1'b0; end
                        1: m_i2 = key_data;
                        2: begin m_ctrl = key_data[1:0]; m_valid = 1'b1; end
                        default: m_valid = 1'b0;
                    endcase
                    m_step = (m_step + 1) % 4;
                end
                m_pe = 1'b0;
                m_pc = 1'b0;
                qe.push_back(key_enter);
                void'(qe.pop_front());
                qc.push_back(key_clear);
                void'(qc.pop_front());
                if (window_differs(qe, m_st_e)) begin
                    m_st_e = ~m_st_e;
                    m_pe   = m_st_e;
                end
                if (window_differs(qc, m_st_c)) begin
                    m_st_c = ~m_st_c;
                    m_pc   = m_st_c;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("model_i1", 32'(i1), 32'(m_i1));
            check_eq("model_i2", 32'(i2), 32'(m_i2));
            check_eq("model_ctrl", 32'(ctrl), 32'(m_ctrl));
            check_eq("model_valid", 32'(operands_valid), 32'(m_valid));
            check_eq("model_state", 32'(entry_state), 32'(m_step));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [3:0] data, input int hold);
        key_data  = data;
        key_enter = 1'b1;
        tick(hold);
        key_enter = 1'b0;
        tick(hold);
    endtask

    task automatic check_set(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                             input logic [1:0] ec, input logic ev, input logic [1:0] es);
        check_eq({tag, "_i1"}, 32'(i1), 32'(e1));
        check_eq({tag, "_i2"}, 32'(i2), 32'(e2));
        check_eq({tag, "_ctrl"}, 32'(ctrl), 32'(ec));
        check_eq({tag, "_valid"}, 32'(operands_valid), 32'(ev));
        check_eq({tag, "_state"}, 32'(entry_state), 32'(es));
    endtask

    initial begin
        tick(3);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        tick(50);
        check_set("idle", 4'hF, 4'hF, 2'h3, 1'b0, 2'd0);

        press(4'b0011, 10);
        check_set("enter_a", 4'b0011, 4'hF, 2'h3, 1'b0, 2'd1);
        press(4'b0101, 10);
        check_set("enter_b", 4'b0011, 4'b0101, 2'h3, 1'b0, 2'd2);
        key_data  = 4'b0010;
        key_enter = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick(1);
            check_eq("valid_edge", 32'(operands_valid), (k == 6) ? 32'd1 : 32'd0);
        end
        tick(3);
        key_enter = 1'b0;
        tick(10);
        check_set("enter_op", 4'b0011, 4'b0101, 2'b10, 1'b1, 2'd3);

        press(4'b0110, 10);
        check_set("show_exit", 4'b0011, 4'b0101, 2'b10, 1'b0, 2'd0);
        press(4'b1001, 10);
        check_set("reenter_a", 4'b1001, 4'b0101, 2'b10, 1'b0, 2'd1);

        key_data = 4'b0111;
        for (int b = 0; b < 4; b++) begin
            key_enter = (b % 2 == 0);
            tick(2);
        end
        key_enter = 1'b1;
        tick(10);
        key_enter = 1'b0;
        tick(10);
        check_set("bounce", 4'b1001, 4'b0111, 2'b10, 1'b0, 2'd2);

        key_data = 4'b0001;
        repeat (4) begin
            key_enter = 1'b1;
            tick(3);
            key_enter = 1'b0;
            tick(3);
        end
        tick(10);
        check_set("glitch", 4'b1001, 4'b0111, 2'b10, 1'b0, 2'd2);

        key_data  = 4'b0001;
        key_enter = 1'b1;
        key_clear = 1'b1;
        tick(10);
        key_enter = 1'b0;
        key_clear = 1'b0;
        tick(10);
        check_set("clear_wins", 4'hF, 4'hF, 2'h3, 1'b0, 2'd0);

        press(4'b1010, 10);
        key_data  = 4'b1100;
        key_enter = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        check_set("async_rst", 4'hF, 4'hF, 2'h3, 1'b0, 2'd0);
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick(1);
            check_eq("held_press_state", 32'(entry_state), (k == 6) ? 32'd1 : 32'd0);
        end
        check_eq("held_press_i1", 32'(i1), 32'hC);
        key_enter = 1'b0;
        tick(10);

        repeat (80) begin
            key_data  = 4'($urandom);
            key_enter = 1'($urandom_range(0, 1));
            key_clear = ($urandom_range(0, 7) == 0);
            tick(int'($urandom_range(1, 8)));
        end
        key_enter = 1'b0;
        key_clear = 1'b0;
        tick(12);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
